// File: rtl/updown_seq_decoder_pkg.sv
// Shared types for the up/down sequence decoder: FSM states, step classes
// and the width of the illegal-jump counter.
package updown_pkg;

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } state_e;

  typedef enum logic [1:0] {
    CLS_HOLD,
    CLS_UP,
    CLS_DOWN,
    CLS_ILLEGAL
  } step_class_e;

  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/updown_seq_decoder_if.sv
// Bundle between the observed counter and the decoder: the sampled count
// going in, and the lock/direction/position/error indications coming out.
interface updown_seq_decoder_if
  import updown_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int POS_W = 8
) ();

  logic                 sample_en;
  logic [WIDTH-1:0]     q;
  logic                 locked;
  logic                 dir;
  logic                 step;
  logic                 dir_change;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [POS_W-1:0]     pos;

  // Side that samples the counter and consumes the decoder's results
  modport master (
    output sample_en, q,
    input  locked, dir, step, dir_change, err, err_cnt, pos
  );

  // The decoder itself
  modport slave (
    input  sample_en, q,
    output locked, dir, step, dir_change, err, err_cnt, pos
  );

endinterface

// File: rtl/updown_step_classify.sv
// Classifies one counter transition by its modular difference: +1 is UP,
// -1 (all ones) is DOWN, 0 is HOLD, anything else is an illegal jump.
module updown_step_classify
  import updown_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] q,
  output step_class_e      cls
);

  logic [WIDTH-1:0] delta;

  // Subtraction wraps naturally, so 7->0 and 0->7 fall out as legal steps
  always_comb begin
    delta = q - prev;
    if (delta == WIDTH'(1))
      cls = CLS_UP;
    else if (delta == '1)
      cls = CLS_DOWN;
    else if (delta == '0)
      cls = CLS_HOLD;
    else
      cls = CLS_ILLEGAL;
  end

endmodule

// File: rtl/updown_seq_decoder.sv
// Checker/decoder beside the 3-bit up/down counter: follows its q bus,
// locks onto the count, tracks direction and signed position, and counts
// illegal jumps, dropping lock after too many in a row.
module updown_seq_decoder
  import updown_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int POS_W     = 8,
  parameter int ERR_LIMIT = 3
) (
  input logic               clk,
  input logic               rst_n,
  updown_seq_decoder_if.slave bus
);

  state_e               state, state_next;
  logic [WIDTH-1:0]     prev, prev_next;
  logic [POS_W-1:0]     pos, pos_next;
  logic                 dir, dir_next;
  logic [3:0]           consec, consec_next;
  logic [ERR_CNT_W-1:0] err_cnt, err_cnt_next;
  logic                 step, step_next;
  logic                 dir_change, dir_change_next;
  logic                 err, err_next;
  step_class_e          cls;
  logic                 is_up;

  updown_step_classify #(.WIDTH(WIDTH)) u_classify (
    .prev (prev),
    .q    (bus.q),
    .cls  (cls)
  );

  assign is_up = (cls == CLS_UP);

  // Next-state and next-output logic; nothing moves unless a sample is taken
  always_comb begin
    state_next      = state;
    prev_next       = prev;
    pos_next        = pos;
    dir_next        = dir;
    consec_next     = consec;
    err_cnt_next    = err_cnt;
    step_next       = 1'b0;
    dir_change_next = 1'b0;
    err_next        = 1'b0;
    if (bus.sample_en) begin
      prev_next = bus.q;
      case (state)
        UNLOCKED: state_next = ACQUIRE;
        ACQUIRE, LOCKED: begin
          case (cls)
            CLS_UP, CLS_DOWN: begin
              step_next       = 1'b1;
              dir_next        = is_up;
              pos_next        = is_up ? pos + POS_W'(1) : pos - POS_W'(1);
              consec_next     = '0;
              dir_change_next = (state == LOCKED) && (is_up != dir);
              state_next      = LOCKED;
            end
            CLS_ILLEGAL: begin
              err_next = 1'b1;
              if (err_cnt != '1)
                err_cnt_next = err_cnt + ERR_CNT_W'(1);
              if (state == LOCKED) begin
                if (consec == 4'(ERR_LIMIT - 1)) begin
                  consec_next = '0;
                  state_next  = UNLOCKED;
                end else begin
                  consec_next = consec + 4'd1;
                end
              end
            end
            default: ;
          endcase
        end
        default: state_next = UNLOCKED;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= UNLOCKED;
      prev       <= '0;
      pos        <= '0;
      dir        <= 1'b0;
      consec     <= '0;
      err_cnt    <= '0;
      step       <= 1'b0;
      dir_change <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      prev       <= prev_next;
      pos        <= pos_next;
      dir        <= dir_next;
      consec     <= consec_next;
      err_cnt    <= err_cnt_next;
      step       <= step_next;
      dir_change <= dir_change_next;
      err        <= err_next;
    end
  end

  assign bus.locked     = (state == LOCKED);
  assign bus.dir        = dir;
  assign bus.step       = step;
  assign bus.dir_change = dir_change;
  assign bus.err        = err;
  assign bus.err_cnt    = err_cnt;
  assign bus.pos        = pos;

endmodule
